// File: rtl/lif_neuron_array.sv
// lif_neuron_array: leaky integrate-and-fire neuron array with signed synapse weights,
// per-neuron threshold/refractory period, all configured through one daisy-chainable shift chain.
module lif_neuron_array #(
    parameter int N_IN       = 10,
    parameter int N_OUT      = 10,
    parameter int W_BITS     = 2,
    parameter int V_BITS     = 8,
    parameter int R_BITS     = 3,
    parameter int LEAK_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              config_en,
    input  logic              bs_in,
    output logic              bs_out,
    input  logic [N_IN-1:0]   dendrite,
    output logic [N_OUT-1:0]  spike
);
    localparam int SEG     = N_IN*W_BITS + V_BITS + R_BITS;
    localparam int CFG_LEN = N_OUT*SEG;
    localparam int T_OFF   = N_IN*W_BITS;
    localparam int R_OFF   = T_OFF + V_BITS;
    localparam int S_BITS  = W_BITS + $clog2(N_IN+1) + 1;
    localparam int VW      = (V_BITS > S_BITS ? V_BITS : S_BITS) + 2;

    logic [CFG_LEN-1:0]       chain;
    logic [V_BITS-1:0]        v [N_OUT];
    logic [V_BITS-1:0]        thr [N_OUT];
    logic [V_BITS-1:0]        vc [N_OUT];
    logic [R_BITS-1:0]        r [N_OUT];
    logic [R_BITS-1:0]        refp [N_OUT];
    logic [N_OUT-1:0]         fire;
    logic [N_OUT-1:0]         hold;
    logic signed [S_BITS-1:0] acc;
    logic signed [VW-1:0]     vn;

    assign bs_out = chain[CFG_LEN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chain <= '0;
        else if (ena && config_en)
            chain <= {chain[CFG_LEN-2:0], bs_in};
    end

    // vn is formed wide and signed so leak and inhibitory weights can never wrap before the clamp
    always_comb begin
        acc = '0;
        vn  = '0;
        for (int j = 0; j < N_OUT; j++) begin
            thr[j]  = chain[j*SEG+T_OFF +: V_BITS];
            refp[j] = chain[j*SEG+R_OFF +: R_BITS];
            acc = '0;
            for (int i = 0; i < N_IN; i++)
                acc = acc + (dendrite[i] ? S_BITS'($signed(chain[j*SEG+i*W_BITS +: W_BITS])) : S_BITS'(0));
            vn = $signed(VW'(v[j])) - $signed(VW'(LEAK_SHIFT == 0 ? '0 : v[j] >> LEAK_SHIFT)) + VW'(acc);
            vc[j]   = vn[VW-1] ? '0 : (|vn[VW-2:V_BITS]) ? '1 : vn[V_BITS-1:0];
            fire[j] = vc[j] >= thr[j];
            hold[j] = config_en || thr[j] == '0 || r[j] != '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                v[j] <= '0;
                r[j] <= '0;
            end
        end else if (ena) begin
            for (int j = 0; j < N_OUT; j++) begin
                spike[j] <= !hold[j] && fire[j];
                v[j]     <= (hold[j] || fire[j]) ? '0 : vc[j];
                r[j]     <= (config_en || thr[j] == '0) ? '0 :
                            (r[j] != '0) ? r[j] - 1'b1 :
                            fire[j] ? refp[j] : '0;
            end
        end
    end
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: scenario tasks for lif_neuron_array checked against an arithmetic
// reference model of the neuron rules plus constant expectations for the directed cases.
module tb_lif_neuron_array;
    localparam int N_IN = 10, N_OUT = 10, W_BITS = 2, V_BITS = 8, R_BITS = 3, LEAK_SHIFT = 3;
    localparam int SEG = N_IN*W_BITS + V_BITS + R_BITS;
    localparam int L   = N_OUT*SEG;

    logic             clk = 0, rst_n = 0, ena = 0, config_en = 0, bs_in = 0;
    logic             bs_out;
    logic [N_IN-1:0]  dendrite = '0;
    logic [N_OUT-1:0] spike;

    int n_checks = 0, n_pass = 0;

    logic [L-1:0]     mc;
    int               mv [N_OUT];
    int               mr [N_OUT];
    logic [N_OUT-1:0] ms;
    int               cw [N_OUT][N_IN];
    int               cthr [N_OUT];
    int               crefp [N_OUT];

    lif_neuron_array #(.N_IN(N_IN), .N_OUT(N_OUT), .W_BITS(W_BITS), .V_BITS(V_BITS),
                       .R_BITS(R_BITS), .LEAK_SHIFT(LEAK_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .config_en(config_en), .bs_in(bs_in),
        .bs_out(bs_out), .dendrite(dendrite), .spike(spike)
    );

    always #5 clk = ~clk;

    function automatic int field(int j, int off, int w);
        int x = 0;
        for (int b = 0; b < w; b++) x = x | (int'(mc[j*SEG+off+b]) << b);
        return x;
    endfunction

    function automatic logic [L-1:0] build_cfg();
        logic [L-1:0] c = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++)
                for (int b = 0; b < W_BITS; b++) c[j*SEG+i*W_BITS+b] = cw[j][i][b];
            for (int b = 0; b < V_BITS; b++) c[j*SEG+N_IN*W_BITS+b] = cthr[j][b];
            for (int b = 0; b < R_BITS; b++) c[j*SEG+N_IN*W_BITS+V_BITS+b] = crefp[j][b];
        end
        return c;
    endfunction

    task automatic model_reset();
        mc = '0;
        ms = '0;
        for (int j = 0; j < N_OUT; j++) begin
            mv[j] = 0;
            mr[j] = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit c, input bit b, input logic [N_IN-1:0] d);
        int thr, s, w, vn;
        if (!e) return;
        if (c) begin
            mc = {mc[L-2:0], b};
            ms = '0;
            for (int j = 0; j < N_OUT; j++) begin
                mv[j] = 0;
                mr[j] = 0;
            end
            return;
        end
        for (int j = 0; j < N_OUT; j++) begin
            thr = field(j, N_IN*W_BITS, V_BITS);
            if (thr == 0) begin
                mv[j] = 0; mr[j] = 0; ms[j] = 0;
            end else if (mr[j] != 0) begin
                mr[j]--; mv[j] = 0; ms[j] = 0;
            end else begin
                s = 0;
                for (int i = 0; i < N_IN; i++) if (d[i]) begin
                    w = field(j, i*W_BITS, W_BITS);
                    if (w >= 2**(W_BITS-1)) w -= 2**W_BITS;
                    s += w;
                end
                vn = mv[j] - (LEAK_SHIFT != 0 ? mv[j] / (2**LEAK_SHIFT) : 0) + s;
                if (vn < 0) vn = 0;
                if (vn > 2**V_BITS-1) vn = 2**V_BITS-1;
                if (vn >= thr) begin
                    ms[j] = 1; mv[j] = 0; mr[j] = field(j, N_IN*W_BITS+V_BITS, R_BITS);
                end else begin
                    ms[j] = 0; mv[j] = vn;
                end
            end
        end
    endtask

    task automatic cyc(input bit e, input bit c, input bit b, input logic [N_IN-1:0] d);
        ena = e; config_en = c; bs_in = b; dendrite = d;
        @(posedge clk);
        model_step(e, c, b, d);
        #1;
    endtask

    task automatic load();
        logic [L-1:0] c = build_cfg();
        for (int k = L-1; k >= 0; k--) cyc(1, 1, c[k], '0);
    endtask

    task automatic clear_cfg();
        for (int j = 0; j < N_OUT; j++) begin
            cthr[j] = 0;
            crefp[j] = 0;
            for (int i = 0; i < N_IN; i++) cw[j][i] = 0;
        end
    endtask

    task automatic random_cfg(input int thr_max);
        for (int j = 0; j < N_OUT; j++) begin
            cthr[j] = $urandom_range(0, thr_max);
            crefp[j] = $urandom_range(0, 2**R_BITS-1);
            for (int i = 0; i < N_IN; i++) cw[j][i] = $urandom_range(0, 3) - 2;
        end
    endtask

    task automatic test_reset();
        random_cfg(6);
        load();
        for (int k = 0; k < 10; k++) cyc(1, 0, 0, N_IN'($urandom));
        #2 rst_n = 0;
        model_reset();
        #1;
        n_checks++;
        if ({spike, bs_out} !== '0) $display("FAIL reset_async spike=%b bs_out=%b want 0", spike, bs_out);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, 0, '1);
            n_checks++;
            if (spike !== '0 || bs_out !== 1'b0)
                $display("FAIL reset_idle cyc=%0d spike=%b bs_out=%b want 0/0", k, spike, bs_out);
            else n_pass++;
        end
    endtask

    task automatic test_chain();
        bit   pat [L];
        logic exp_bo = 0;
        int   t = 0;
        bit   b;
        for (int k = 0; k < L; k++) pat[k] = 1'($urandom);
        for (int idx = 0; idx < 2*L; idx++) begin
            b = idx < L ? pat[idx] : 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                cyc(0, 1, ~b, '0);
                n_checks++;
                if (bs_out !== exp_bo) $display("FAIL chain_hold t=%0d bs_out=%b want %b", t, bs_out, exp_bo);
                else n_pass++;
            end
            cyc(1, 1, b, '0);
            t++;
            exp_bo = t >= L ? pat[t-L] : 1'b0;
            n_checks++;
            if (bs_out !== exp_bo) $display("FAIL chain_shift t=%0d bs_out=%b want %b", t, bs_out, exp_bo);
            else n_pass++;
        end
    endtask

    task automatic test_integrate(input int refp, input int period, input int fire_ph);
        clear_cfg();
        cw[0][0] = 1; cthr[0] = 4; crefp[0] = refp;
        load();
        for (int k = 1; k <= 3*period; k++) begin
            cyc(1, 0, 0, N_IN'(1));
            n_checks++;
            if (spike !== {{(N_OUT-1){1'b0}}, (k % period) == fire_ph} || spike !== ms)
                $display("FAIL integrate refp=%0d edge=%0d spike=%b want %b", refp, k, spike, ms);
            else n_pass++;
            n_checks++;
            if (dut.v[0] !== V_BITS'(mv[0])) $display("FAIL integrate_v edge=%0d v=%0d want %0d", k, dut.v[0], mv[0]);
            else n_pass++;
        end
    endtask

    task automatic test_inhibit_clamp();
        clear_cfg();
        cw[1][0] = -2; cw[1][1] = 1; cthr[1] = 4;
        load();
        for (int k = 0; k < 10; k++) begin
            cyc(1, 0, 0, N_IN'(3));
            n_checks++;
            if (spike !== '0 || dut.v[1] !== '0) $display("FAIL inhibit cyc=%0d spike=%b v=%0d want 0/0", k, spike, dut.v[1]);
            else n_pass++;
        end
        for (int i = 0; i < N_IN; i++) cw[1][i] = 1;
        cthr[1] = 255;
        load();
        for (int k = 0; k < 40; k++) begin
            cyc(1, 0, 0, '1);
            n_checks++;
            if (spike !== '0 || dut.v[1] !== V_BITS'(mv[1]))
                $display("FAIL saturate cyc=%0d spike=%b v=%0d want 0/%0d", k, spike, dut.v[1], mv[1]);
            else n_pass++;
        end
        n_checks++;
        if (dut.v[1] !== 8'd80) $display("FAIL leak_equilibrium v=%0d want 80", dut.v[1]);
        else n_pass++;
    endtask

    task automatic test_midop();
        clear_cfg();
        cw[0][0] = 1; cthr[0] = 4;
        load();
        repeat (3) cyc(1, 0, 0, N_IN'(1));
        n_checks++;
        if (dut.v[0] !== 8'd3) $display("FAIL midop_v3 v=%0d want 3", dut.v[0]);
        else n_pass++;
        load();
        n_checks++;
        if (dut.v[0] !== 8'd0 || spike !== '0) $display("FAIL midop_cfg_clear v=%0d spike=%b want 0", dut.v[0], spike);
        else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 0, 0, N_IN'(1));
            n_checks++;
            if (spike[0] !== (k == 4) || spike !== ms) $display("FAIL midop_restart edge=%0d spike=%b want %b", k, spike, ms);
            else n_pass++;
        end
        repeat (2) begin
            cyc(0, 0, 0, '0);
            n_checks++;
            if (spike[0] !== 1'b1) $display("FAIL freeze_spike_hold spike=%b want 1", spike[0]);
            else n_pass++;
        end
        repeat (2) cyc(1, 0, 0, N_IN'(1));
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, N_IN'(1));
            n_checks++;
            if (dut.v[0] !== 8'd2 || spike[0] !== 1'b0) $display("FAIL freeze cyc=%0d v=%0d spike=%b want 2/0", k, dut.v[0], spike[0]);
            else n_pass++;
        end
        for (int k = 1; k <= 2; k++) begin
            cyc(1, 0, 0, N_IN'(1));
            n_checks++;
            if (spike[0] !== (k == 2) || spike !== ms) $display("FAIL resume edge=%0d spike=%b want %b", k, spike, ms);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit e, c;
        for (int trial = 0; trial < 3; trial++) begin
            random_cfg(30);
            load();
            for (int k = 0; k < 150; k++) begin
                e = $urandom_range(0, 9) != 0;
                c = $urandom_range(0, 24) == 0;
                cyc(e, c, 1'($urandom), N_IN'($urandom));
                n_checks++;
                if (spike !== ms) $display("FAIL random_spike trial=%0d cyc=%0d spike=%b want %b", trial, k, spike, ms);
                else n_pass++;
                for (int j = 0; j < N_OUT; j++) begin
                    n_checks++;
                    if (dut.v[j] !== V_BITS'(mv[j])) $display("FAIL random_v trial=%0d cyc=%0d n=%0d v=%0d want %0d", trial, k, j, dut.v[j], mv[j]);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        clear_cfg();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        test_reset();
        test_chain();
        test_integrate(0, 4, 0);
        test_integrate(2, 6, 4);
        test_inhibit_clamp();
        test_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
